// File: rtl/deco_7seg_scan.sv
// deco_7seg_scan: multiplexed N-digit hex 7-segment driver with double-buffered load and leading-zero blanking.
module deco_7seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lzb_en_i,
  input  logic                  blank_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  frame_o
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic SP = SEG_ACTIVE_LOW != 0;
  localparam logic DP = DIG_ACTIVE_LOW != 0;

  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_sh_val, r_disp_val;
  logic [DIGITS-1:0]   r_sh_dp, r_disp_dp;
  logic [6:0]          r_seg;
  logic                r_dp, r_frame;
  logic [DIGITS-1:0]   r_dig;

  logic                w_tick, w_last, w_frame, w_lz;
  logic [4*DIGITS-1:0] w_hi;
  logic [DIGITS-1:0]   w_dps, w_onehot;
  logic [6:0]          w_dec, w_seg;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  // Shifting the display down by the index leaves only this digit and the ones above it,
  // so an all-zero remainder means this digit is a leading zero.
  always_comb begin
    w_tick   = r_pre == PW'(REFRESH_DIV - 1);
    w_last   = r_idx == IW'(DIGITS - 1);
    w_frame  = w_tick && w_last;
    w_hi     = r_disp_val >> {r_idx, 2'b00};
    w_dps    = r_disp_dp >> r_idx;
    w_onehot = DIGITS'(1) << r_idx;
    w_lz     = lzb_en_i && r_idx != '0 && w_hi == '0;
    w_dec    = decode(w_hi[3:0]);
    w_seg    = w_lz ? 7'b0 : w_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= '0;
      r_idx      <= '0;
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_seg      <= {7{SP}};
      r_dp       <= SP;
      r_dig      <= {DIGITS{DP}};
      r_frame    <= 1'b0;
    end else begin
      r_pre      <= w_tick ? '0 : r_pre + 1'b1;
      r_idx      <= w_tick ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
      r_sh_val   <= load_i ? value_i : r_sh_val;
      r_sh_dp    <= load_i ? dp_i : r_sh_dp;
      r_disp_val <= w_frame ? r_sh_val : r_disp_val;
      r_disp_dp  <= w_frame ? r_sh_dp : r_disp_dp;
      r_seg      <= w_seg ^ {7{SP}};
      r_dp       <= w_dps[0] ^ SP;
      r_dig      <= (blank_i ? '0 : w_onehot) ^ {DIGITS{DP}};
      r_frame    <= w_frame;
    end
  end

  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign dig_o   = r_dig;
  assign frame_o = r_frame;
endmodule

// File: tb/tb_deco_7seg_scan.sv
// tb_deco_7seg_scan: randomized and directed checks of the scan driver against a frame-arithmetic model.
module tb_deco_7seg_scan;
  logic        clk = 0, rst = 1;
  logic [15:0] value_i = 0;
  logic        load_i = 0, lzb_en_i = 0, blank_i = 0;
  logic [3:0]  dp_i = 0;
  logic [6:0]  seg_o, seg_n;
  logic        dp_o, dp_n, frame_o, frame_n;
  logic [3:0]  dig_o, dig_n;
  int          n_chk = 0, n_pass = 0;

  deco_7seg_scan #(.DIGITS(4), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i), .dp_i(dp_i), .lzb_en_i(lzb_en_i),
    .blank_i(blank_i), .seg_o(seg_o), .dp_o(dp_o), .dig_o(dig_o), .frame_o(frame_o));

  deco_7seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_inv (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i), .dp_i(dp_i), .lzb_en_i(lzb_en_i),
    .blank_i(blank_i), .seg_o(seg_n), .dp_o(dp_n), .dig_o(dig_n), .frame_o(frame_n));

  always #5 clk = ~clk;

  localparam logic [6:0] LUT [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                      7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  // Model: position in the scan follows from the number of clocks since reset.
  int          m_e, m_idx;
  logic [15:0] m_sv, m_dv, m_hi;
  logic [3:0]  m_sd, m_dd, x_dig;
  logic [6:0]  x_seg;
  logic        x_dp, x_frm;

  always @(posedge clk) begin
    if (rst) begin
      m_e = 0; m_sv = 0; m_sd = 0; m_dv = 0; m_dd = 0;
      x_seg = 0; x_dp = 0; x_dig = 0; x_frm = 0;
    end else begin
      m_idx = (m_e / 4) % 4;
      m_hi  = m_dv >> (4 * m_idx);
      x_seg = (lzb_en_i && m_idx > 0 && m_hi == 0) ? 7'h00 : LUT[m_hi[3:0]];
      x_dp  = m_dd[m_idx];
      x_dig = blank_i ? 4'h0 : 4'(1 << m_idx);
      x_frm = (m_e % 16) == 15;
      if (x_frm) begin m_dv = m_sv; m_dd = m_sd; end
      if (load_i) begin m_sv = value_i; m_sd = dp_i; end
      m_e++;
    end
  end

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({dig_o, seg_o, dp_o, frame_o} !== 13'h0)
      $display("FAIL reset_hi got %h want %h", {dig_o, seg_o, dp_o, frame_o}, 13'h0);
    else n_pass++;
    n_chk++;
    if ({dig_n, seg_n, dp_n, frame_n} !== 13'b1111_1111111_1_0)
      $display("FAIL reset_lo got %b want %b", {dig_n, seg_n, dp_n, frame_n}, 13'b1111_1111111_1_0);
    else n_pass++;
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({dig_o, seg_o} !== {4'b0001, 7'b0111111})
      $display("FAIL first_digit got %b want %b", {dig_o, seg_o}, {4'b0001, 7'b0111111});
    else n_pass++;
    n_chk++;
    if ({dig_n, seg_n} !== {4'b1110, 7'b1000000})
      $display("FAIL first_digit_inv got %b want %b", {dig_n, seg_n}, {4'b1110, 7'b1000000});
    else n_pass++;
  endtask

  task automatic test_idle;
    int frames = 0;
    repeat (48) begin
      @(negedge clk);
      frames += int'(frame_o);
      n_chk++;
      if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
        $display("FAIL idle got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
      else n_pass++;
    end
    n_chk++;
    if (frames !== 3) $display("FAIL idle_frames got %0d want 3", frames);
    else n_pass++;
  endtask

  task automatic test_load;
    repeat (5) @(negedge clk);
    value_i = 16'h1A3F; dp_i = 4'b0100; load_i = 1;
    @(negedge clk);
    load_i = 0;
    repeat (40) begin
      @(negedge clk);
      n_chk++;
      if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
        $display("FAIL load got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
      else n_pass++;
      n_chk++;
      if ({dig_n, seg_n, dp_n} !== ~{x_dig, x_seg, x_dp})
        $display("FAIL load_inv got %b want %b", {dig_n, seg_n, dp_n}, ~{x_dig, x_seg, x_dp});
      else n_pass++;
    end
  endtask

  task automatic test_lzb;
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    lzb_en_i = 1;
    for (int k = 0; k < 2; k++) begin
      value_i = vals[k]; dp_i = 4'b0; load_i = 1;
      @(negedge clk);
      load_i = 0;
      repeat (40) begin
        @(negedge clk);
        n_chk++;
        if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
          $display("FAIL lzb got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
        else n_pass++;
      end
    end
    lzb_en_i = 0;
  endtask

  task automatic test_frame_load;
    for (int k = 0; k < 2; k++) begin
      while (m_e % 16 != 15) @(negedge clk);
      value_i = 16'($urandom); dp_i = 4'($urandom); load_i = 1;
      @(negedge clk);
      load_i = 0;
      repeat (36) begin
        @(negedge clk);
        n_chk++;
        if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
          $display("FAIL frame_load got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
        else n_pass++;
      end
    end
  endtask

  task automatic test_blank;
    value_i = 16'h8421; dp_i = 4'b0100; load_i = 1;
    @(negedge clk);
    load_i = 0;
    repeat (20) @(negedge clk);
    blank_i = 1;
    repeat (17) begin
      @(negedge clk);
      n_chk++;
      if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
        $display("FAIL blank got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
      else n_pass++;
    end
    blank_i = 0;
    repeat (20) begin
      @(negedge clk);
      n_chk++;
      if (dp_o !== (dig_o == 4'b0100))
        $display("FAIL dp_follow got dp=%b dig=%b want dp only on 0100", dp_o, dig_o);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    repeat (400) begin
      @(negedge clk);
      n_chk++;
      if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
        $display("FAIL random got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
      else n_pass++;
      n_chk++;
      if ({dig_n, seg_n, dp_n, frame_n} !== {~x_dig, ~x_seg, ~x_dp, x_frm})
        $display("FAIL random_inv got %b want %b", {dig_n, seg_n, dp_n, frame_n}, {~x_dig, ~x_seg, ~x_dp, x_frm});
      else n_pass++;
      value_i  = 16'($urandom);
      dp_i     = 4'($urandom);
      load_i   = $urandom_range(0, 7) == 0;
      lzb_en_i = $urandom_range(0, 1) == 1;
      blank_i  = $urandom_range(0, 9) == 0;
    end
    load_i = 0; blank_i = 0; lzb_en_i = 0;
  endtask

  task automatic test_reset_mid;
    value_i = 16'hBEEF; dp_i = 4'hF; load_i = 1;
    @(negedge clk);
    load_i = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (40) begin
      @(negedge clk);
      n_chk++;
      if ({dig_o, seg_o, dp_o, frame_o} !== {x_dig, x_seg, x_dp, x_frm})
        $display("FAIL reset_mid got %b want %b", {dig_o, seg_o, dp_o, frame_o}, {x_dig, x_seg, x_dp, x_frm});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_load;
    test_lzb;
    test_frame_load;
    test_blank;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
